reg_operand_fetch: RTL and testbench
====================================

Name: reg_operand_fetch

Overview:
- Read-side counterpart of the register write-select path. Holds the CPU register file, which is written by the ALU/decoder write-select value.
- Delivers registered operand pairs (A, B) to the ALU over a valid/ready handshake.
- Operand B is either a register or the decoder literal.
- Write-to-read forwarding ensures a register written in the same cycle as a read is seen immediately.

Parameters:
- DataWidth, 8, width of registers, literal and operands
- AdrWidth, 3, register address width; register count = 2**AdrWidth

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  register write strobe from the write-select path
- wr_adr  in  AdrWidth  register written when wr_en=1
- wr_val  in  DataWidth  value written (ALU result or decoder literal, already selected)
- req_valid  in  1  decoder presents an operand request
- req_ready  out  1  block can accept a request this cycle
- rd_adr_a  in  AdrWidth  source register for operand A
- rd_adr_b  in  AdrWidth  source register for operand B
- sel_op_b_literal  in  1  1 = operand B from literal, 0 = from register rd_adr_b
- literal  in  DataWidth  decoder literal/immediate
- op_valid  out  1  op_a/op_b hold a valid operand pair
- op_ready  in  1  ALU consumes the pair this cycle
- op_a  out  DataWidth  operand A
- op_b  out  DataWidth  operand B

Behaviour:
- Reset (async, active-high):
  - all registers = 0
  - op_valid = 0, op_a = 0, op_b = 0
  - req_ready = 1 once reset deasserts
- Register write: on each rising edge with wr_en=1, reg[wr_adr] <= wr_val. Writes are independent of the request/operand handshake.
- req_ready = !op_valid || op_ready (combinational). The output stage is a single entry; there is no deeper buffering.
- Accept = req_valid && req_ready. On the accepting edge:
  - op_a <= fwd(rd_adr_a)
  - op_b <= sel_op_b_literal ? literal : fwd(rd_adr_b)
  - op_valid <= 1
  - Latency: request to op_valid is 1 cycle.
- fwd(x) = (wr_en && wr_adr==x) ? wr_val : reg[x]. This gives same-cycle write-then-read forwarding for both ports, including rd_adr_a == rd_adr_b.
- States of the output stage:
  - EMPTY (op_valid=0): accept → FULL.
  - FULL with op_ready=0: hold op_a/op_b/op_valid stable, req_ready=0.
  - FULL with op_ready=1 and accept: reload new pair, stay FULL (back-to-back, 1 pair/cycle).
  - FULL with op_ready=1 and no accept: → EMPTY. op_a/op_b keep their last values.
- Snapshot semantics: a held pair is not updated by later writes to its source registers.
- Literal path bypasses the register file entirely. rd_adr_b is ignored when sel_op_b_literal=1.
- Reset asserted mid-stall: the pending pair is discarded, op_valid drops immediately (async), and register contents are cleared.

Optional Feature:
- Macro OPFETCH_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0 on both ports, including via forwarding.
  - Writes to address 0 are discarded.
- Undefined: register 0 is an ordinary general-purpose register.

Decomposition:
- Package opfetch_pkg holds:
  - default DataWidth/AdrWidth constants
  - SEL_OPB_REG = 0, SEL_OPB_LIT = 1
  - register-count constant
- One sub-module: reg_file_storage. It contains the storage array with one synchronous write port, two asynchronous read ports and the zero-register option. Forwarding and the handshake stage stay in reg_operand_fetch.

Test Plan:
- Reset then write reg3 = 8'h44; request A=3, B=literal 8'hF3 → next cycle op_valid=1, op_a=8'h44, op_b=8'hF3.
- Same-edge wr_en to reg5 = 8'hA5 while requesting A=5, B=5 (register) → op_a=op_b=8'hA5, not the old value.
- op_ready=0 for 3 cycles with a pair held; meanwhile write its source reg → op_a/op_b unchanged, req_ready=0, op_valid=1 throughout.
- req_valid and op_ready held 1 for 4 cycles with changing addresses → one new pair every cycle, req_ready constantly 1.
- Assert reset while op_valid=1 → op_valid=0 and op_a=0 without a clock edge; a subsequent read of reg3 returns 8'h00.
- With OPFETCH_ZERO_REG_EN: write reg0 = 8'hFF then read A=0 → op_a=8'h00. Without the macro → op_a=8'hFF.

Source files
------------

// File: rtl/opfetch_pkg.sv
// Shared constants and types for the register operand-fetch block.
// Optional feature macro: OPFETCH_ZERO_REG_EN (register 0 hard-wired to zero).
package opfetch_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADR_WIDTH_DEF  = 3;
    localparam int REG_COUNT_DEF  = 1 << ADR_WIDTH_DEF;

    // Operand B source select
    localparam logic SEL_OPB_REG = 1'b0;
    localparam logic SEL_OPB_LIT = 1'b1;

    // Single-entry output stage occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/reg_operand_fetch_if.sv
// Write-select, operand request and operand delivery signals of reg_operand_fetch.
// slave = the fetch block, master = the decoder/ALU side driving it.
interface reg_operand_fetch_if
    import opfetch_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int AdrWidth  = ADR_WIDTH_DEF
) ();

    logic                 wr_en;
    logic [AdrWidth-1:0]  wr_adr;
    logic [DataWidth-1:0] wr_val;
    logic                 req_valid;
    logic                 req_ready;
    logic [AdrWidth-1:0]  rd_adr_a;
    logic [AdrWidth-1:0]  rd_adr_b;
    logic                 sel_op_b_literal;
    logic [DataWidth-1:0] literal;
    logic                 op_valid;
    logic                 op_ready;
    logic [DataWidth-1:0] op_a;
    logic [DataWidth-1:0] op_b;

    modport slave (
        input  wr_en, wr_adr, wr_val,
        input  req_valid, rd_adr_a, rd_adr_b, sel_op_b_literal, literal,
        output req_ready,
        output op_valid, op_a, op_b,
        input  op_ready
    );

    modport master (
        output wr_en, wr_adr, wr_val,
        output req_valid, rd_adr_a, rd_adr_b, sel_op_b_literal, literal,
        input  req_ready,
        input  op_valid, op_a, op_b,
        output op_ready
    );

endinterface

// File: rtl/reg_file_storage.sv
// CPU register file: one synchronous write port, two asynchronous read ports.
// With OPFETCH_ZERO_REG_EN, register 0 ignores writes and always reads zero.
module reg_file_storage
    import opfetch_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int AdrWidth  = ADR_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [AdrWidth-1:0]  i_wr_adr,
    input  logic [DataWidth-1:0] i_wr_val,
    input  logic [AdrWidth-1:0]  i_rd_adr_a,
    input  logic [AdrWidth-1:0]  i_rd_adr_b,
    output logic [DataWidth-1:0] o_rd_dat_a,
    output logic [DataWidth-1:0] o_rd_dat_b
);

    localparam int RegCount = 1 << AdrWidth;

    logic [DataWidth-1:0] r_mem [RegCount];
    logic                 w_wr_accept;

`ifdef OPFETCH_ZERO_REG_EN
    assign w_wr_accept = i_wr_en && (i_wr_adr != '0);
    assign o_rd_dat_a  = (i_rd_adr_a == '0) ? '0 : r_mem[i_rd_adr_a];
    assign o_rd_dat_b  = (i_rd_adr_b == '0) ? '0 : r_mem[i_rd_adr_b];
`else
    assign w_wr_accept = i_wr_en;
    assign o_rd_dat_a  = r_mem[i_rd_adr_a];
    assign o_rd_dat_b  = r_mem[i_rd_adr_b];
`endif

    // Storage array: cleared by reset, written on the rising edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RegCount; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_mem[i_wr_adr] <= i_wr_val;
        end
    end

endmodule

// File: rtl/reg_operand_fetch.sv
// Register operand fetch: register file plus a single-entry registered output
// stage delivering operand pairs (A, B) over valid/ready, with same-cycle
// write-to-read forwarding. Optional macro: OPFETCH_ZERO_REG_EN.
module reg_operand_fetch
    import opfetch_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int AdrWidth  = ADR_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    reg_operand_fetch_if.slave bus
);

    stage_state_t         r_state, w_state_nxt;
    logic [DataWidth-1:0] r_op_a_p1, r_op_b_p1;
    logic [DataWidth-1:0] w_rd_a, w_rd_b;
    logic [DataWidth-1:0] w_fwd_a, w_fwd_b, w_op_b_src;
    logic                 w_hit_a, w_hit_b;
    logic                 w_req_ready, w_accept;

    reg_file_storage #(
        .DataWidth (DataWidth),
        .AdrWidth  (AdrWidth)
    ) u_rf (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_wr_en    (bus.wr_en),
        .i_wr_adr   (bus.wr_adr),
        .i_wr_val   (bus.wr_val),
        .i_rd_adr_a (bus.rd_adr_a),
        .i_rd_adr_b (bus.rd_adr_b),
        .o_rd_dat_a (w_rd_a),
        .o_rd_dat_b (w_rd_b)
    );

    // A write landing on the same edge as a read is forwarded; register 0
    // never forwards when it is hard-wired to zero.
`ifdef OPFETCH_ZERO_REG_EN
    assign w_hit_a = bus.wr_en && (bus.wr_adr == bus.rd_adr_a) && (bus.rd_adr_a != '0);
    assign w_hit_b = bus.wr_en && (bus.wr_adr == bus.rd_adr_b) && (bus.rd_adr_b != '0);
`else
    assign w_hit_a = bus.wr_en && (bus.wr_adr == bus.rd_adr_a);
    assign w_hit_b = bus.wr_en && (bus.wr_adr == bus.rd_adr_b);
`endif

    assign w_fwd_a    = w_hit_a ? bus.wr_val : w_rd_a;
    assign w_fwd_b    = w_hit_b ? bus.wr_val : w_rd_b;
    assign w_op_b_src = (bus.sel_op_b_literal == SEL_OPB_LIT) ? bus.literal : w_fwd_b;

    assign w_req_ready = (r_state == ST_EMPTY) || bus.op_ready;
    assign w_accept    = bus.req_valid && w_req_ready;

    // Output stage occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy: load on accept, drain when consumed without a refill
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (bus.op_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---- stage p1: operand pair snapshot, loaded only on accept ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a_p1 <= '0;
            r_op_b_p1 <= '0;
        end else if (w_accept) begin
            r_op_a_p1 <= w_fwd_a;
            r_op_b_p1 <= w_op_b_src;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.op_valid  = (r_state == ST_FULL);
    assign bus.op_a      = r_op_a_p1;
    assign bus.op_b      = r_op_b_p1;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Self-checking bench for reg_operand_fetch: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_reg_operand_fetch;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_operand_fetch_if #(.DataWidth(8), .AdrWidth(3)) bus ();

    reg_operand_fetch #(.DataWidth(8), .AdrWidth(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    logic [7:0] m_regs [8];
    logic       m_valid;
    logic [7:0] m_a, m_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] x);
`ifdef OPFETCH_ZERO_REG_EN
        if (x == 3'd0) return 8'h00;
`endif
        if (bus.wr_en && bus.wr_adr == x) return bus.wr_val;
        return m_regs[x];
    endfunction

    function automatic bit m_wr_ok(input logic [2:0] x);
`ifdef OPFETCH_ZERO_REG_EN
        return x != 3'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_valid = 1'b0;
        m_a = 8'h00;
        m_b = 8'h00;
    endtask

    // One clock: evaluate the model on the pre-edge inputs, commit at the edge
    task automatic tick();
        bit         acc, wr;
        logic [7:0] na, nb, wv;
        logic [2:0] wa;
        acc = bus.req_valid && (!m_valid || bus.op_ready);
        na  = m_read(bus.rd_adr_a);
        nb  = bus.sel_op_b_literal ? bus.literal : m_read(bus.rd_adr_b);
        wr  = bus.wr_en && m_wr_ok(bus.wr_adr);
        wa  = bus.wr_adr;
        wv  = bus.wr_val;
        @(posedge clk);
        if (acc) begin
            m_a = na; m_b = nb; m_valid = 1'b1;
        end else if (m_valid && bus.op_ready) begin
            m_valid = 1'b0;
        end
        if (wr) m_regs[wa] = wv;
        #1;
    endtask

    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wv,
                        input logic rv, input logic [2:0] ra, input logic [2:0] rb,
                        input logic sl, input logic [7:0] lit, input logic ordy);
        bus.wr_en = we; bus.wr_adr = wa; bus.wr_val = wv;
        bus.req_valid = rv; bus.rd_adr_a = ra; bus.rd_adr_b = rb;
        bus.sel_op_b_literal = sl; bus.literal = lit; bus.op_ready = ordy;
        tick();
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("op_valid", bus.op_valid, m_valid);
            chk("req_ready", bus.req_ready, !m_valid || bus.op_ready);
            chk("op_a", bus.op_a, m_a);
            chk("op_b", bus.op_b, m_b);
        end
    end

    initial begin
        reset = 1'b1;
        bus.wr_en = 0; bus.wr_adr = 0; bus.wr_val = 0;
        bus.req_valid = 0; bus.rd_adr_a = 0; bus.rd_adr_b = 0;
        bus.sel_op_b_literal = 0; bus.literal = 0; bus.op_ready = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_valid", bus.op_valid, 1'b0);
        chk("rst_op_a", bus.op_a, 8'h00);
        chk("rst_op_b", bus.op_b, 8'h00);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        cmp_en = 1'b1;

        // Write reg3, then request A=3, B=literal
        step(1, 3'd3, 8'h44, 0, 3'd0, 3'd0, 0, 8'h00, 0);
        step(0, 3'd0, 8'h00, 1, 3'd3, 3'd0, 1, 8'hF3, 0);
        chk("lit_op_valid", bus.op_valid, 1'b1);
        chk("lit_op_a", bus.op_a, 8'h44);
        chk("lit_op_b", bus.op_b, 8'hF3);

        // Drain, then same-edge write/read forwarding on both ports
        step(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 8'h00, 1);
        step(1, 3'd5, 8'hA5, 1, 3'd5, 3'd5, 0, 8'h00, 0);
        chk("fwd_op_a", bus.op_a, 8'hA5);
        chk("fwd_op_b", bus.op_b, 8'hA5);

        // Stall three cycles while overwriting the source register
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd5, 8'h11, 1, 3'd3, 3'd3, 0, 8'h00, 0);
            chk("stall_op_a", bus.op_a, 8'hA5);
            chk("stall_op_b", bus.op_b, 8'hA5);
            chk("stall_req_ready", bus.req_ready, 1'b0);
            chk("stall_op_valid", bus.op_valid, 1'b1);
        end

        // Back-to-back: one pair per cycle, reg3=44 and reg5=11
        for (int i = 0; i < 4; i++) begin
            bus.op_ready = 1'b1;
            #1;
            chk("b2b_req_ready", bus.req_ready, 1'b1);
            step(0, 3'd0, 8'h00, 1, (i % 2 == 0) ? 3'd3 : 3'd5, 3'd0, 1, 8'(8'h30 + i), 1);
            chk("b2b_op_valid", bus.op_valid, 1'b1);
            chk("b2b_op_a", bus.op_a, (i % 2 == 0) ? 8'h44 : 8'h11);
            chk("b2b_op_b", bus.op_b, 8'(8'h30 + i));
        end

        // Register 0 behaviour
        step(1, 3'd0, 8'hFF, 0, 3'd0, 3'd0, 0, 8'h00, 1);
        step(0, 3'd0, 8'h00, 1, 3'd0, 3'd0, 1, 8'h00, 0);
`ifdef OPFETCH_ZERO_REG_EN
        chk("zero_reg_op_a", bus.op_a, 8'h00);
`else
        chk("zero_reg_op_a", bus.op_a, 8'hFF);
`endif

        // Reset while a pair is stalled
        step(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 8'h00, 1);
        step(0, 3'd0, 8'h00, 1, 3'd3, 3'd3, 0, 8'h00, 0);
        chk("pre_rst_op_a", bus.op_a, 8'h44);
        #1;
        cmp_en = 1'b0;
        reset  = 1'b1;
        m_reset();
        #1;
        chk("async_rst_op_valid", bus.op_valid, 1'b0);
        chk("async_rst_op_a", bus.op_a, 8'h00);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cmp_en = 1'b1;
        step(0, 3'd0, 8'h00, 1, 3'd3, 3'd3, 0, 8'h00, 0);
        chk("post_rst_reg3_a", bus.op_a, 8'h00);
        chk("post_rst_reg3_b", bus.op_b, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
